// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - IF/ID stall/flush scheduler with load-use detection and mult/div sequencing
module hazard_sched #(
  parameter int MUL_CYC = 4,
  parameter int DIV_CYC = 32,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] rdEX,
  input  logic       lwEX,
  input  logic       GPRWrEX,
  input  logic       brTakenID,
  input  logic       mdReqID,
  input  logic       mdDivID,
  input  logic       hiloRdID,
  output logic       PCWr,
  output logic       IFIDWr,
  output logic       IFIDFlush,
  output logic       IDEXFlush,
  output logic       mdStart,
  output logic       mdDone,
  output logic       mdBusy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYC - 1);

  state_t           state, stateNxt;
  logic [CNT_W-1:0] cnt, cntNxt;
  logic             luStall, mdStall, stall;
  logic             startInt, doneInt, busyInt;

  assign luStall = lwEX & GPRWrEX & (rdEX != 5'd0) & ((rdEX == rs) | (rdEX == rt));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    startInt = 1'b0;
    doneInt  = 1'b0;
    busyInt  = 1'b0;
    case (state)
      IDLE: begin
        // Busy is 0 here, so a load-use hazard is the only thing holding a launch back.
        if (mdReqID && !luStall) begin
          startInt = 1'b1;
          stateNxt = mdDivID ? DIV : MUL;
          cntNxt   = mdDivID ? DIV_LD : MUL_LD;
        end
      end
      MUL, DIV: begin
        busyInt = 1'b1;
        if (cnt == '0) stateNxt = DONE;
        else           cntNxt   = cnt - CNT_W'(1);
      end
      DONE: begin
        busyInt  = 1'b1;
        doneInt  = 1'b1;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  assign mdStall = busyInt & (mdReqID | hiloRdID);
  assign stall   = luStall | mdStall;

  always_comb begin
    PCWr      = 1'b1;
    IFIDWr    = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    mdStart   = 1'b0;
    mdDone    = 1'b0;
    mdBusy    = 1'b0;
    if (clr) begin
      PCWr      = 1'b0;
      IFIDWr    = 1'b0;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else begin
      mdStart = startInt;
      mdDone  = doneInt;
      mdBusy  = busyInt;
      // Stall wins over a taken branch; the branch is re-evaluated once operands are ready.
      if (stall) begin
        PCWr      = 1'b0;
        IFIDWr    = 1'b0;
        IDEXFlush = 1'b1;
      end else if (brTakenID) begin
        IFIDFlush = 1'b1;
      end
    end
  end

endmodule
